// File: rtl/types_pkg.sv
// Shared types for the arithmetic datapath and the controller that time-shares it.
package types_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2
    } opr_mode_t;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

    // Wide enough for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } share_tag_t;

endpackage

// File: rtl/add_sub_mult.sv
// Two-stage add/sub/multiply datapath; operand a is sw low half, b is sw high half.
module add_sub_mult
    import types_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] sw,
    input  opr_mode_t       selector,
    output logic [BITS-1:0] led
);

    localparam int HB = BITS / 2;

    logic [BITS-1:0] op_a;
    logic [BITS-1:0] op_b;
    logic [BITS-1:0] result;
    logic [BITS-1:0] result_q;

    assign op_a = BITS'(sw[HB-1:0]);
    assign op_b = BITS'(sw[BITS-1:HB]);

    always_comb begin
        case (selector)
            SUB:     result = op_a - op_b;
            MUL:     result = op_a * op_b;
            default: result = op_a + op_b;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            led      <= '0;
        end else begin
            result_q <= result;
            led      <= result_q;
        end
    end

endmodule

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr wins, wrapping at NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    int idx;

    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one add_sub_mult datapath among NREQ requesters; results return tagged by requester id.
module alu_share_ctrl
    import types_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int BITS    = 16,
    parameter int ALU_LAT = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic [NREQ-1:0]                   req_valid,
    output logic [NREQ-1:0]                   req_ready,
    input  opr_mode_t [NREQ-1:0]              req_op,
    input  logic [NREQ-1:0][BITS/2-1:0]       req_a,
    input  logic [NREQ-1:0][BITS/2-1:0]       req_b,
    output opr_mode_t                         alu_sel,
    output logic [BITS-1:0]                   alu_sw,
    input  logic [BITS-1:0]                   alu_led,
    output logic                              resp_valid,
    output logic [$clog2(NREQ)-1:0]           resp_id,
    output logic [BITS-1:0]                   resp_data,
    output logic                              busy,
    output logic                              idle,
    output logic [15:0]                       op_count
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(ALU_LAT + 2);

    ctrl_state_t     state;
    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic            issue;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    share_tag_t      pipe [ALU_LAT];

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant & {NREQ{en && (state == RUN) && grant_any}};
    assign issue     = |req_ready;
    assign busy      = (inflight != '0);
    assign idle      = (state == HALT);
    assign resp_data = alu_led;

    always_comb begin
        inflight_next = inflight;
        if (issue && !resp_valid) begin
            inflight_next = inflight + CW'(1);
        end else if (!issue && resp_valid) begin
            inflight_next = inflight - CW'(1);
        end
    end

    // Leaving RUN/DRAIN looks at the post-edge in-flight count so idle rises right after the last response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HALT;
        end else begin
            case (state)
                HALT:    if (en) state <= RUN;
                RUN:     if (!en) state <= (inflight_next == '0) ? HALT : DRAIN;
                DRAIN: begin
                    if (en) begin
                        state <= RUN;
                    end else if (inflight_next == '0) begin
                        state <= HALT;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

    // NOTE: the tag pipe is small control state, so it is reset; discarding in-flight tags depends on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ALU_LAT; i++) begin
                pipe[i] <= '0;
            end
            resp_valid <= 1'b0;
            resp_id    <= '0;
            inflight   <= '0;
            op_count   <= '0;
        end else begin
            pipe[0] <= issue ? share_tag_t'{valid: 1'b1, id: TAG_ID_W'(grant_idx)} : '0;
            for (int i = 1; i < ALU_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            resp_valid <= pipe[ALU_LAT-1].valid;
            resp_id    <= IDW'(pipe[ALU_LAT-1].id);
            inflight   <= inflight_next;
            if (resp_valid) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_sw  <= '0;
            alu_sel <= ADD;
            rr_ptr  <= '0;
        end else if (issue) begin
            alu_sw  <= {req_b[grant_idx], req_a[grant_idx]};
            alu_sel <= req_op[grant_idx];
            rr_ptr  <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench: handshakes push model results, a monitor pops them as responses arrive.
`timescale 1ns/1ps
module tb_alu_share_ctrl;
    import types_pkg::*;

    localparam int NREQ    = 4;
    localparam int BITS    = 16;
    localparam int ALU_LAT = 2;
    localparam int HB      = BITS / 2;
    localparam int IDW     = $clog2(NREQ);

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        en;
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    opr_mode_t [NREQ-1:0]        req_op;
    logic [NREQ-1:0][HB-1:0]     req_a;
    logic [NREQ-1:0][HB-1:0]     req_b;
    opr_mode_t                   alu_sel;
    logic [BITS-1:0]             alu_sw;
    logic [BITS-1:0]             alu_led;
    logic                        resp_valid;
    logic [IDW-1:0]              resp_id;
    logic [BITS-1:0]             resp_data;
    logic                        busy;
    logic                        idle;
    logic [15:0]                 op_count;

    always #5 clk = ~clk;

    alu_share_ctrl #(.NREQ(NREQ), .BITS(BITS), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_sel(alu_sel), .alu_sw(alu_sw), .alu_led(alu_led),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .busy(busy), .idle(idle), .op_count(op_count)
    );

    add_sub_mult #(.BITS(BITS)) u_alu (
        .clk(clk), .rst_n(rst_n), .sw(alu_sw), .selector(alu_sel), .led(alu_led)
    );

    typedef struct {
        int              id;
        logic [BITS-1:0] data;
        int              due;
    } exp_t;

    exp_t            exp_q[$];
    int              grant_log[$];
    int              checks = 0;
    int              fails = 0;
    int              cyc = 0;
    int              hs_count = 0;
    int              resp_seen = 0;
    int              wait_cnt[NREQ];
    logic [NREQ-1:0] last_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic straight from the operation definitions, wrapped to BITS.
    function automatic logic [BITS-1:0] ref_result(opr_mode_t op, logic [HB-1:0] a, logic [HB-1:0] b);
        int r;
        case (op)
            SUB:     r = int'(a) - int'(b);
            MUL:     r = int'(a) * int'(b);
            default: r = int'(a) + int'(b);
        endcase
        return r[BITS-1:0];
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: every response must match the oldest outstanding expectation, on its due cycle.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            resp_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL spurious_resp: got resp_valid=1 id=%0d, expected no response", resp_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_id", 32'(resp_id), 32'(e.id));
                check("resp_data", 32'(resp_data), 32'(e.data));
                check("resp_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic sample();
        if (!rst_n) begin
            last_acc = '0;
            return;
        end
        check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        check("ready_subset_valid", 32'(req_ready & ~req_valid), 32'd0);
        if (!en) check("ready_needs_en", 32'(req_ready), 32'd0);
        last_acc = req_ready & req_valid;
        for (int i = 0; i < NREQ; i++) begin
            if (last_acc[i]) begin
                exp_q.push_back('{id: i, data: ref_result(req_op[i], req_a[i], req_b[i]), due: cyc + 1 + ALU_LAT});
                grant_log.push_back(i);
                hs_count++;
                check("rr_wait_bound", 32'(wait_cnt[i] <= NREQ + 1), 32'd1);
                wait_cnt[i] = 0;
            end else if (req_valid[i] && en) begin
                wait_cnt[i]++;
                if (wait_cnt[i] == NREQ + 2) check("rr_starvation", 32'(wait_cnt[i]), 32'(NREQ + 1));
            end else begin
                wait_cnt[i] = 0;
            end
        end
    endtask

    // One clock: sample at the falling edge, return just after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        en = 1'b0;
        req_valid = '0;
        exp_q.delete();
        resp_seen = 0;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle();
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rand_payload(input int i);
        req_op[i] = opr_mode_t'($urandom_range(0, 2));
        req_a[i] = HB'($urandom);
        req_b[i] = HB'($urandom);
    endtask

    task automatic issue_ops(input int n);
        int target;
        int guard;
        target = hs_count + n;
        guard = 0;
        req_valid = 4'b0001;
        while (hs_count < target && guard < n + 50) begin
            rand_payload(0);
            cycle();
            guard++;
        end
        req_valid = '0;
        check("issue_ops_count", 32'(hs_count), 32'(target));
    endtask

    initial begin
        int exp_order[5];
        int hs0;
        exp_order = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        en = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_op[i] = ADD;
            req_a[i] = '0;
            req_b[i] = '0;
            wait_cnt[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'(ADD));
        check("rst_alu_sw", 32'(alu_sw), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_op_count", 32'(op_count), 32'd0);
        rst_n = 1'b1;
        en = 1'b1;
        @(posedge clk);
        #1;
        check("run_after_reset", 32'(idle), 32'd0);

        // Single add, accepted in the cycle it is presented.
        req_op[0] = ADD;
        req_a[0] = 8'h12;
        req_b[0] = 8'h34;
        req_valid = 4'b0001;
        #1;
        check("single_ready", 32'(req_ready), 32'b0001);
        cycle();
        req_valid = '0;
        wait_drain();
        check("single_op_count", 32'(op_count), 32'd1);

        // Round robin from a fresh pointer.
        reset_dut();
        grant_log.delete();
        for (int i = 0; i < NREQ; i++) begin
            req_op[i] = MUL;
            req_a[i] = HB'(i + 1);
            req_b[i] = 8'd3;
        end
        req_valid = '1;
        repeat (5) cycle();
        req_valid = '0;
        check("rr_grant_count", 32'(grant_log.size()), 32'd5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) check("rr_grant_order", 32'(grant_log[k]), 32'(exp_order[k]));
        wait_drain();

        // Subtraction wrapping below zero.
        req_op[2] = SUB;
        req_a[2] = 8'h01;
        req_b[2] = 8'h02;
        req_valid = 4'b0100;
        #1;
        check("sub_ready", 32'(req_ready), 32'b0100);
        cycle();
        req_valid = '0;
        wait_drain();

        // Drain: three back-to-back issues, then en drops while req1 waits.
        hs0 = hs_count;
        req_valid = 4'b0001;
        repeat (3) begin
            rand_payload(0);
            cycle();
        end
        check("drain_issues", 32'(hs_count - hs0), 32'd3);
        en = 1'b0;
        req_valid = 4'b0010;
        #1;
        check("drain_ready_blocked", 32'(req_ready), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
        cycle();
        check("drain_idle_n4", 32'(idle), 32'd0);
        cycle();
        check("drain_idle_n5", 32'(idle), 32'd0);
        cycle();
        check("drain_idle_after_last", 32'(idle), 32'd1);
        check("drain_busy_after_last", 32'(busy), 32'd0);
        check("drain_all_resp", 32'(exp_q.size()), 32'd0);
        req_valid = '0;
        en = 1'b1;
        cycle();

        // Reset one cycle after two issues: nothing may come out.
        req_valid = 4'b0001;
        repeat (2) begin
            rand_payload(0);
            cycle();
        end
        rst_n = 1'b0;
        req_valid = '0;
        exp_q.delete();
        resp_seen = 0;
        #1;
        check("midrst_op_count", 32'(op_count), 32'd0);
        check("midrst_alu_sw", 32'(alu_sw), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) cycle();
        check("midrst_no_resp", 32'(resp_seen), 32'd0);
        check("midrst_op_count_after", 32'(op_count), 32'd0);

        // Random traffic with en toggling.
        reset_dut();
        for (int t = 0; t < 3000; t++) begin
            if (en) begin
                if ($urandom_range(0, 15) == 0) en = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                en = 1'b1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    rand_payload(i);
                    req_valid[i] = 1'b1;
                end
            end
            cycle();
            req_valid = req_valid & ~last_acc;
        end
        req_valid = '0;
        en = 1'b1;
        wait_drain();
        check("rand_op_count", 32'(op_count), 32'(resp_seen[15:0]));

        // Completed-response counter wraps after 65536.
        reset_dut();
        issue_ops(65535);
        wait_drain();
        check("wrap_op_count_max", 32'(op_count), 32'hFFFF);
        issue_ops(1);
        wait_drain();
        check("wrap_op_count_zero", 32'(op_count), 32'd0);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
